// File: rtl/rf_update_if.sv
// rf_update_if: per-core command handshake and shared memory read port of rf_update
interface rf_update_if #(parameter int NCORES = 2);
  logic [NCORES-1:0]    cmd_valid;
  logic [NCORES-1:0]    cmd_ready;
  logic [2*NCORES-1:0]  cmd_op;
  logic [16*NCORES-1:0] cmd_tag;
  logic [16*NCORES-1:0] cmd_val;
  logic                 mem_req;
  logic [15:0]          mem_addr;
  logic                 mem_gnt;
  logic                 mem_rvalid;
  logic [15:0]          mem_rdata;
  modport master (
    output cmd_valid, cmd_op, cmd_tag, cmd_val, mem_gnt, mem_rvalid, mem_rdata,
    input  cmd_ready, mem_req, mem_addr
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_tag, cmd_val, mem_gnt, mem_rvalid, mem_rdata,
    output cmd_ready, mem_req, mem_addr
  );
endinterface

// File: rtl/rf_update.sv
// rf_update: per-core register file with command updates and round-robin serialised memory fills
module rf_update #(
  parameter int NCORES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rf_update_if.slave             bus,
  output logic [35*NCORES-1:0]   rf_out,
  output logic [NCORES-1:0]      fill_done
);
  localparam int IW = $clog2(NCORES);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t                    state, nstate;
  logic [NCORES-1:0]         valid, retr, locked;
  logic [NCORES-1:0][15:0]   tag, val;
  logic [IW-1:0]             idx, rr, sel;
  logic [15:0]               addr;
  // a retrieving entry is owned by the fill engine, so its core is stalled
  assign bus.cmd_ready = ~retr;
  // pack the entries, MSB first: valid, retrieving, locked, tag, val
  always_comb begin
    rf_out = '0;
    for (int i = 0; i < NCORES; i++) rf_out[35*i +: 35] = {valid[i], retr[i], locked[i], tag[i], val[i]};
  end
  // first retrieving entry at or after rr; scanning backwards lets the closest one win
  always_comb begin
    sel = rr;
    for (int k = NCORES-1; k >= 0; k--)
      if (retr[IW'((int'(rr) + k) % NCORES)]) sel = IW'((int'(rr) + k) % NCORES);
  end
  // entry storage: core commands, plus the fill write-back for the in-flight entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid  <= '0;
      retr   <= '0;
      locked <= '0;
      tag    <= '0;
      val    <= '0;
    end else begin
      for (int i = 0; i < NCORES; i++)
        if (bus.cmd_valid[i] && !retr[i])
          case (bus.cmd_op[2*i +: 2])
            2'b00: begin
              tag[i]   <= bus.cmd_tag[16*i +: 16];
              val[i]   <= bus.cmd_val[16*i +: 16];
              valid[i] <= 1'b1;
            end
            2'b01: begin
              tag[i]   <= bus.cmd_tag[16*i +: 16];
              valid[i] <= 1'b0;
              retr[i]  <= 1'b1;
            end
            2'b10:   locked[i] <= 1'b1;
            default: locked[i] <= 1'b0;
          endcase
      if (state == WAIT && bus.mem_rvalid) begin
        val[idx]   <= bus.mem_rdata;
        retr[idx]  <= 1'b0;
        valid[idx] <= 1'b1;
      end
    end
  // fill FSM state register; reset abandons any outstanding read
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nstate;
  // fill FSM next state; data arriving outside WAIT is never consumed
  always_comb
    nstate = state == IDLE ? (|retr ? REQ : IDLE) :
             state == REQ  ? (bus.mem_gnt ? WAIT : REQ) :
                             (bus.mem_rvalid ? IDLE : WAIT);
  // latch the selected entry and its address, pulse completion, advance the round-robin pointer
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx       <= '0;
      rr        <= '0;
      addr      <= '0;
      fill_done <= '0;
    end else begin
      fill_done <= '0;
      if (state == IDLE && |retr) begin
        idx  <= sel;
        addr <= tag[sel];
      end
      if (state == WAIT && bus.mem_rvalid) begin
        fill_done[idx] <= 1'b1;
        rr             <= int'(idx) == NCORES-1 ? '0 : idx + 1'b1;
      end
    end
  // fill FSM outputs: the request is exactly the REQ state, address held from selection
  always_comb begin
    bus.mem_req  = state == REQ;
    bus.mem_addr = addr;
  end
endmodule
